// File: rtl/rx_frame_loader_pkg.sv
// Shared types and constants for the serial frame-buffer loader.
// State codes double as the 7-seg debug value.
package rx_frame_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_CHECK = 4'd2,
    ST_DONE  = 4'd3,
    ST_ERR   = 4'd4
  } state_t;

  localparam int unsigned DEF_IMG_W = 64;
  localparam int unsigned DEF_IMG_H = 64;
  localparam int unsigned NPIX = DEF_IMG_W * DEF_IMG_H;
  localparam logic [7:0] DEF_SOF = 8'hAA;

  function automatic int unsigned npix(
    input int unsigned w,
    input int unsigned h
  );
    return w * h;
  endfunction

endpackage

// File: rtl/rx_frame_loader_timeout.sv
// Idle-clock watchdog: sync clear, enable, terminal-count pulse.
// tc fires on the LIMIT-th enabled clock after a clear.
module rx_frame_loader_timeout #(
  parameter int unsigned LIMIT = 434000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  assign tc = en & ~clr & (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tc) cnt <= '0;
      else    cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_loader.sv
// Loads one SOF-prefixed grayscale frame from the UART into frame RAM.
// Optional trailing checksum: define RX_FRAME_LOADER_CHECKSUM_EN.
module rx_frame_loader
  import rx_frame_loader_pkg::*;
#(
  parameter int unsigned IMG_W       = DEF_IMG_W,
  parameter int unsigned IMG_H       = DEF_IMG_H,
  parameter int unsigned ADDR_W      = 12,
  parameter logic [7:0]  SOF_BYTE    = DEF_SOF,
  parameter int unsigned TIMEOUT_CYC = 434000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_pronto,
  input  logic [7:0]        rx_dados,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [3:0]        db_estado
);

  localparam int unsigned NPIX_L = npix(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX_L - 1);

  state_t state, nstate;

  logic              pronto_q;
  logic              ev_q;
  logic [7:0]        byte_q;
  logic [ADDR_W-1:0] count;
  logic              wr_fire;
  logic              last_pix;
  logic              tmo_tc;
  logic              in_frame;

`ifdef RX_FRAME_LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  // byte is captured on the pronto rising edge and acted on one clock later
  always_ff @(posedge clock) begin
    if (reset) begin
      pronto_q <= 1'b0;
      ev_q     <= 1'b0;
      byte_q   <= '0;
    end else begin
      pronto_q <= rx_pronto;
      ev_q     <= rx_pronto & ~pronto_q;
      if (rx_pronto & ~pronto_q) byte_q <= rx_dados;
    end
  end

  assign last_pix = (count == LAST_ADDR);
  assign in_frame = (state == ST_LOAD) || (state == ST_CHECK);

  rx_frame_loader_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (ev_q | ~in_frame),
    .en    (in_frame),
    .tc    (tmo_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate  = state;
    wr_fire = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ev_q && byte_q == SOF_BYTE) nstate = ST_LOAD;
      end
      ST_LOAD: begin
        if (ev_q) begin
          wr_fire = 1'b1;
`ifdef RX_FRAME_LOADER_CHECKSUM_EN
          if (last_pix) nstate = ST_CHECK;
`else
          if (last_pix) nstate = ST_DONE;
`endif
        end else if (tmo_tc) begin
          nstate = ST_ERR;
        end
      end
`ifdef RX_FRAME_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (ev_q)        nstate = (byte_q == sum) ? ST_DONE : ST_ERR;
        else if (tmo_tc) nstate = ST_ERR;
      end
`endif
      ST_DONE: nstate = ST_IDLE;
      ST_ERR:  nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (state == ST_IDLE) begin
      count <= '0;
    end else if (wr_fire) begin
      count <= last_pix ? '0 : count + 1'b1;
    end
  end

`ifdef RX_FRAME_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset || state == ST_IDLE) sum <= '0;
    else if (wr_fire)              sum <= sum + byte_q;
  end
`endif

  assign wr_en      = wr_fire;
  assign wr_addr    = count;
  assign wr_data    = byte_q;
  assign busy       = in_frame;
  assign frame_done = (state == ST_DONE);
  assign frame_err  = (state == ST_ERR);
  assign db_estado  = state;

endmodule

// File: tb/tb_rx_frame_loader.sv
// Directed bench for rx_frame_loader with a transaction-level model.
// Build with RX_FRAME_LOADER_CHECKSUM_EN to cover the checksum path.
module tb_rx_frame_loader;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int ADDR_W = 3;
  localparam int TMO = 200;
  localparam int NPX = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_pronto = 1'b0;
  logic [7:0] rx_dados = '0;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic busy;
  logic frame_done;
  logic frame_err;
  logic [3:0] db_estado;

  always #5 clk = ~clk;

  rx_frame_loader #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .ADDR_W      (ADDR_W),
    .SOF_BYTE    (8'hAA),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .rx_pronto  (rx_pronto),
    .rx_dados   (rx_dados),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .db_estado  (db_estado)
  );

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  wr_t q[$];
  wr_t e;
  logic [7:0] mem [0:NPX-1];
  int n_wr = 0;
  int seen_done = 0;
  int seen_err = 0;
  int exp_done = 0;
  int exp_err = 0;

  bit m_in = 0;
  bit m_chk = 0;
  int m_cnt = 0;
  logic [7:0] m_sum = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (q.size() == 0) begin
          chk("unexpected_wr", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", int'(wr_addr), e.a);
          chk("wr_data", int'(wr_data), e.d);
          chk("wr_cycle", cyc, e.c);
        end
        mem[wr_addr] = wr_data;
        n_wr++;
        chk("wr_while_busy", int'(busy), 1);
      end
      if (frame_done) begin
        seen_done++;
        chk("done_busy_low", int'(busy), 0);
      end
      if (frame_err) begin
        seen_err++;
        chk("err_busy_low", int'(busy), 0);
      end
    end
  end

  // model: decide the fate of each byte from the frame rules
  task automatic model_byte(input logic [7:0] b, input int at);
    if (!m_in) begin
      if (b == 8'hAA) begin
        m_in = 1;
        m_chk = 0;
        m_cnt = 0;
        m_sum = '0;
      end
    end else if (m_chk) begin
      if (b == m_sum) exp_done++;
      else            exp_err++;
      m_in = 0;
      m_chk = 0;
    end else begin
      q.push_back('{a: m_cnt, d: int'(b), c: at + 1});
      m_sum = m_sum + b;
      m_cnt++;
      if (m_cnt == NPX) begin
`ifdef RX_FRAME_LOADER_CHECKSUM_EN
        m_chk = 1;
`else
        exp_done++;
        m_in = 0;
`endif
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_dados = b;
    rx_pronto = 1'b1;
    model_byte(b, cyc);
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    rx_pronto = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_frame();
`ifdef RX_FRAME_LOADER_CHECKSUM_EN
    send_byte(m_sum, 1);
`endif
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] step);
    send_byte(8'hAA, 1);
    for (int i = 0; i < NPX; i++) send_byte(base + 8'(i) * step, 1);
    finish_frame();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (m_in && n >= TMO + 2) begin
      exp_err++;
      m_in = 0;
      m_chk = 0;
    end
  endtask

  task automatic end_test(input string name);
    repeat (6) @(negedge clk);
    chk({name, "_queue_empty"}, q.size(), 0);
    chk({name, "_done_count"}, seen_done, exp_done);
    chk({name, "_err_count"}, seen_err, exp_err);
    chk({name, "_busy_idle"}, int'(busy), 0);
  endtask

  int w0, d0, e0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_state", int'(db_estado), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    reset = 1'b0;

    // 1: plain frame 0..7
    w0 = n_wr; d0 = seen_done;
    send_byte(8'hAA, 1);
    chk("t1_state_load", int'(db_estado), 1);
    chk("t1_busy", int'(busy), 1);
    for (int i = 0; i < NPX; i++) send_byte(8'(i), 1);
    finish_frame();
    end_test("t1");
    chk("t1_writes", n_wr - w0, 8);
    chk("t1_done_pulses", seen_done - d0, 1);
    chk("t1_mem7", int'(mem[7]), 7);

    // 2: junk before SOF is ignored
    w0 = n_wr;
    send_byte(8'h55, 1);
    send_byte(8'h10, 1);
    chk("t2_busy_junk", int'(busy), 0);
    chk("t2_no_wr_junk", n_wr - w0, 0);
    send_frame(8'h30, 8'h01);
    end_test("t2");
    chk("t2_mem0", int'(mem[0]), 8'h30);
    chk("t2_writes", n_wr - w0, 8);

    // 3: timeout mid-frame
    d0 = seen_done; e0 = seen_err;
    send_byte(8'hAA, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    idle(TMO + 50);
    end_test("t3");
    chk("t3_err_pulse", seen_err - e0, 1);
    chk("t3_no_done", seen_done - d0, 0);
    chk("t3_state_idle", int'(db_estado), 0);

    // 4: held pronto counts once, SOF as pixel data
    w0 = n_wr;
    send_byte(8'hAA, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 5);
    send_byte(8'hAA, 1);
    for (int i = 3; i < NPX; i++) send_byte(8'h60 + 8'(i), 1);
    finish_frame();
    end_test("t4");
    chk("t4_writes", n_wr - w0, 8);
    chk("t4_mem1", int'(mem[1]), 8'h22);
    chk("t4_mem2_sof", int'(mem[2]), 8'hAA);

    // 5: reset mid-frame aborts silently
    e0 = seen_err;
    send_byte(8'hAA, 1);
    for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i), 1);
    @(negedge clk);
    reset = 1'b1;
    m_in = 0;
    @(negedge clk);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_state", int'(db_estado), 0);
    chk("t5_rst_addr", int'(wr_addr), 0);
    chk("t5_rst_wr_en", int'(wr_en), 0);
    reset = 1'b0;
    send_frame(8'h80, 8'h03);
    end_test("t5");
    chk("t5_no_err", seen_err - e0, 0);
    chk("t5_mem0", int'(mem[0]), 8'h80);
    chk("t5_mem7", int'(mem[7]), 8'h95);

`ifdef RX_FRAME_LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    w0 = n_wr; d0 = seen_done; e0 = seen_err;
    send_byte(8'hAA, 1);
    for (int i = 1; i <= NPX; i++) send_byte(8'(i), 1);
    chk("t6_model_sum", int'(m_sum), 8'h24);
    send_byte(8'h24, 1);
    end_test("t6a");
    chk("t6_done", seen_done - d0, 1);
    send_byte(8'hAA, 1);
    for (int i = 1; i <= NPX; i++) send_byte(8'(i), 1);
    send_byte(8'h25, 1);
    end_test("t6b");
    chk("t6_err", seen_err - e0, 1);
    chk("t6_writes", n_wr - w0, 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
